// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads 1- or 2-byte instructions from synchronous
// program memory and presents them to the controller over valid/ready.
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLB,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] F0   = 3'd1;
    localparam logic [2:0] W0   = 3'd2;
    localparam logic [2:0] F1   = 3'd3;
    localparam logic [2:0] W1   = 3'd4;
    localparam logic [2:0] PRES = 3'd5;
    localparam logic [2:0] HALT = 3'd6;

    localparam logic [3:0] OP_STOP = 4'b1111;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;

    function automatic logic is_imm(input logic [3:0] op);
        return (op == 4'b0111) || (op == 4'b1010) || (op == 4'b1101);
    endfunction

    // NOTE: every register here, including the instruction fields, is cleared by
    // the async reset and updated only with non-blocking assignments.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state   <= IDLE;
            pc      <= '0;
            opcode  <= '0;
            operand <= '0;
            imm     <= '0;
            pc_out  <= '0;
        end else if (redirect && state != IDLE) begin
            // Redirect wins over everything, including a completing handshake.
            pc    <= redirect_addr;
            state <= F0;
        end else begin
            case (state)
                IDLE: state <= F0;
                F0:   state <= W0;
                W0: begin
                    opcode  <= mem_rdata[7:4];
                    operand <= mem_rdata[3:0];
                    imm     <= '0;
                    pc_out  <= pc;
                    state   <= is_imm(mem_rdata[7:4]) ? F1 : PRES;
                end
                F1:   state <= W1;
                W1: begin
                    imm   <= mem_rdata[7:0];
                    state <= PRES;
                end
                PRES: begin
                    if (instr_ready) begin
                        pc    <= pc + (is_imm(opcode) ? ADDR_W'(2) : ADDR_W'(1));
                        state <= (opcode == OP_STOP) ? HALT : F0;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: outputs decode from state only, with a default for every signal so
    // no latch can be inferred.
    always_comb begin
        mem_rd      = 1'b0;
        mem_addr    = pc;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            F0:   mem_rd = 1'b1;
            F1: begin
                mem_rd   = 1'b1;
                mem_addr = pc + ADDR_W'(1);
            end
            PRES: instr_valid = 1'b1;
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against an instruction-level model of the fetch PC.
module tb_instr_fetch;

    logic       CLK = 1'b0;
    logic       CLB = 1'b0;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] imm;
    logic [7:0] pc_out;
    logic       redirect = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic       halted;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Instruction-level model: where the next instruction lives and whether a STOP was consumed.
    logic [7:0] m_pc;
    logic       m_halted;
    logic       m_idle;
    logic       hold_prev;

    instr_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK(CLK), .CLB(CLB), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .imm(imm), .pc_out(pc_out),
        .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Synchronous program memory: data appears the cycle after the strobe.
    always @(posedge CLK) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic two_byte(input logic [3:0] op);
        return op == 4'h7 || op == 4'hA || op == 4'hD;
    endfunction

    task automatic model_reset();
        m_pc      = 8'h00;
        m_halted  = 1'b0;
        m_idle    = 1'b1;
        hold_prev = 1'b0;
    endtask

    // Called just after a falling edge: drives inputs, checks the current cycle
    // against the model, advances the model across the rising edge.
    task automatic cycle(input logic rdy, input logic rd_en, input logic [7:0] raddr);
        logic [7:0] b0, pc1, exp_addr;
        instr_ready   = rdy;
        redirect      = rd_en;
        redirect_addr = raddr;
        #1;
        b0  = mem[m_pc];
        pc1 = m_pc + 8'd1;
        if (hold_prev) check("hold_valid", instr_valid, 1);
        if (m_halted) begin
            check("halt_rd", mem_rd, 0);
            check("halt_valid", instr_valid, 0);
        end
        if (instr_valid) begin
            check("opcode", opcode, b0[7:4]);
            check("operand", operand, b0[3:0]);
            check("imm", imm, two_byte(b0[7:4]) ? mem[pc1] : 8'h00);
            check("pc_out", pc_out, m_pc);
        end
        if (mem_rd) begin
            exp_addr = (two_byte(b0[7:4]) && mem_addr == pc1) ? pc1 : m_pc;
            check("fetch_addr", mem_addr, exp_addr);
        end
        hold_prev = instr_valid && !rdy && !rd_en;
        if (rd_en && !m_idle) begin
            m_pc     = raddr;
            m_halted = 1'b0;
        end else if (instr_valid && rdy) begin
            if (b0[7:4] == 4'hF) m_halted = 1'b1;
            m_pc = m_pc + (two_byte(b0[7:4]) ? 8'd2 : 8'd1);
        end
        m_idle = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("halted", halted, m_halted);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_op"}, {opcode, operand}, 0);
        check({tag, "_imm"}, imm, 0);
        check({tag, "_pcout"}, pc_out, 0);
        check({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h13;
        mem[8'h04] = 8'hD5;
        mem[8'h05] = 8'hA7;

        // Reset values while CLB is held low.
        #3;
        check_reset_outputs("rst");
        @(negedge CLK);
        CLB = 1'b1;
        model_reset();

        // 1-byte fetch and latency from reset release.
        check("t1_idle_rd", mem_rd, 0);
        cycle(1, 0, 0);
        check("t1_f0_rd", mem_rd, 1);
        check("t1_f0_addr", mem_addr, 8'h00);
        cycle(1, 0, 0);
        check("t1_w0_valid", instr_valid, 0);
        cycle(1, 0, 0);
        check("t1_valid", instr_valid, 1);
        check("t1_fields", {opcode, operand, imm, pc_out}, 24'h13_00_00);
        cycle(1, 0, 0);
        check("t1_next_addr", mem_addr, 8'h01);

        // Immediate instruction at 0x04, then backpressure.
        cycle(0, 1, 8'h04);
        check("t2_addr0", mem_addr, 8'h04);
        run(2, 0);
        check("t2_rd1", mem_rd, 1);
        check("t2_addr1", mem_addr, 8'h05);
        run(2, 0);
        check("t2_fields", {opcode, operand, imm, pc_out}, 24'hD5_A7_04);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0);
            check("bp_valid", instr_valid, 1);
            check("bp_rd", mem_rd, 0);
            check("bp_fields", {opcode, operand, imm, pc_out}, 24'hD5_A7_04);
        end
        cycle(1, 0, 0);
        check("t2_next_addr", mem_addr, 8'h06);

        // Immediate instruction at 0xFF takes its imm from 0x00; PC wraps to 0x01.
        mem[8'hFF] = 8'h70;
        mem[8'h00] = 8'h3C;
        cycle(0, 1, 8'hFF);
        run(2, 0);
        check("wrap_imm_addr", mem_addr, 8'h00);
        run(2, 0);
        check("wrap_fields", {opcode, operand, imm, pc_out}, 24'h70_3C_FF);
        cycle(1, 0, 0);
        check("wrap_next_addr", mem_addr, 8'h01);

        // Redirect during W1 discards the instruction.
        mem[8'h20] = 8'hA1;
        mem[8'h21] = 8'h55;
        mem[8'h40] = 8'h21;
        cycle(0, 1, 8'h20);
        run(3, 0);
        cycle(0, 1, 8'h40);
        check("rw1_addr", mem_addr, 8'h40);
        check("rw1_valid", instr_valid, 0);
        cycle(0, 0, 0);
        check("rw1_w0_valid", instr_valid, 0);
        cycle(0, 0, 0);
        check("rw1_fields", {instr_valid, opcode, operand, pc_out}, {1'b1, 16'h21_40});
        // Redirect together with ready in PRES.
        cycle(1, 1, 8'h50);
        check("rdy_redir_addr", mem_addr, 8'h50);
        check("rdy_redir_rd", mem_rd, 1);

        // STOP parks the sequencer until redirect.
        mem[8'h02] = 8'hF0;
        cycle(0, 1, 8'h02);
        run(2, 0);
        check("stop_op", opcode, 4'hF);
        cycle(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("park_halted", halted, 1);
            check("park_rd", mem_rd, 0);
            cycle(1, 0, 0);
        end
        cycle(0, 1, 8'h10);
        check("unpark_halted", halted, 0);
        check("unpark_addr", mem_addr, 8'h10);
        check("unpark_rd", mem_rd, 1);
        // Redirect while presenting STOP with ready goes to F0, not HALT.
        cycle(0, 1, 8'h02);
        run(2, 0);
        cycle(1, 1, 8'h10);
        check("stop_redir_halted", halted, 0);
        check("stop_redir_addr", mem_addr, 8'h10);

        // Reset during F1 aborts everything immediately.
        mem[8'h10] = 8'h7A;
        mem[8'h11] = 8'h99;
        run(2, 0);
        check("f1_addr", mem_addr, 8'h11);
        #2 CLB = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        CLB = 1'b1;
        model_reset();
        cycle(1, 0, 0);
        check("restart_addr", mem_addr, 8'h00);
        check("restart_rd", mem_rd, 1);

        // Randomized program, ready and redirects against the model.
        CLB = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge CLK);
        CLB = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, d;
            r = ($urandom_range(0, 9) < 7);
            d = m_halted ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 4);
            cycle(r, d, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch sequencer for the 8-bit CPU; the producer side of the opcode/control path.
- Reads instruction bytes from synchronous program memory and assembles 1-byte or 2-byte (immediate) instructions.
- Presents opcode, operand and immediate to the controller over a valid/ready handshake.
- Owns the fetch PC, accepts branch redirects, and parks on STOP (opcode 4'b1111).

Parameters:
- ADDR_W, 8, program memory address / PC width.
- DATA_W, 8, program memory word width; byte format: [7:4] opcode, [3:0] operand.

Ports:
- CLK  input  1  system clock, rising edge.
- CLB  input  1  clear bar; asynchronous, active-low reset.
- mem_rd  output  1  read strobe to program memory.
- mem_addr  output  ADDR_W  read address; valid while mem_rd=1.
- mem_rdata  input  DATA_W  read data; valid the cycle after mem_rd.
- instr_valid  output  1  instruction fields valid.
- instr_ready  input  1  controller accepts the instruction.
- opcode  output  4  byte0[7:4].
- operand  output  4  byte0[3:0].
- imm  output  8  second byte for immediate opcodes; 0 otherwise.
- pc_out  output  ADDR_W  address of byte0 of the presented instruction.
- redirect  input  1  load a new fetch PC.
- redirect_addr  input  ADDR_W  target address.
- halted  output  1  STOP consumed; fetching suspended.

Behaviour:
- Reset (CLB=0, async): state=IDLE, pc=0, instr_valid=0, opcode=0, operand=0, imm=0, pc_out=0, halted=0, mem_rd=0, mem_addr=0.
- Immediate opcodes (2-byte): 4'b0111, 4'b1010, 4'b1101. All other opcodes are 1-byte.
- States: IDLE, F0, W0, F1, W1, PRES, HALT.
- IDLE: go to F0 on the next edge unconditionally.
- F0: mem_rd=1, mem_addr=pc. Go to W0.
- W0: capture mem_rdata into opcode/operand, capture pc into pc_out, set imm=0.
  - Immediate opcode: go to F1.
  - Otherwise: go to PRES.
- F1: mem_rd=1, mem_addr=pc+1 (mod 2^ADDR_W). Go to W1.
- W1: capture mem_rdata into imm. Go to PRES.
- PRES: instr_valid=1.
  - All output fields held stable while instr_ready=0.
  - On instr_ready=1, pc advances by 1 (1-byte) or 2 (immediate).
  - Then go to F0, or to HALT if opcode=4'b1111.
- HALT: halted=1, mem_rd=0, instr_valid=0. Only redirect or reset leaves HALT.
- mem_rd is 0 in IDLE, W0, W1, PRES, HALT.
- Latency: a 1-byte instruction is valid 2 edges after entering F0; an immediate instruction after 4 edges. Minimum 3 cycles per 1-byte instruction (F0, W0, PRES).
- PC arithmetic is modulo 2^ADDR_W:
  - 0xFF+1 wraps to 0x00.
  - An immediate instruction at 0xFF reads its imm from 0x00.
  - A 2-byte advance from 0xFE wraps to 0x00.
- Redirect (sampled on the edge, any state except IDLE):
  - pc <= redirect_addr, instr_valid drops next cycle, halted clears, next state F0.
  - Any in-flight fetch data is discarded.
- Redirect in PRES with instr_ready=1 in the same cycle: the current instruction counts as consumed (handshake completes), and redirect_addr wins over the sequential PC.
- Redirect while presenting STOP with ready: go to F0 at redirect_addr, not HALT.
- Reset mid-fetch: all state aborts immediately. After release, fetch restarts at address 0.

Test Plan:
- Reset release, mem[0]=0x13, ready=1 -> mem_rd at addr 0x00 one cycle after IDLE; instr_valid on the 3rd edge with opcode=1, operand=3, imm=0, pc_out=0x00. Next fetch at addr 0x01.
- mem[4]=0xD5, mem[5]=0xA7, pc=4 -> reads at 0x04 then 0x05; opcode=0xD, operand=5, imm=0xA7, pc_out=0x04. Next fetch at 0x06.
- Backpressure: instr_ready=0 for 5 cycles in PRES -> fields and instr_valid stable, no mem_rd. PC advances only on the cycle ready=1.
- Wrap: mem[0xFF]=0x70, mem[0x00]=0x3C -> imm=0x3C, pc_out=0xFF. Next fetch at 0x01.
- Redirect during W1 with redirect_addr=0x40 -> imm read discarded, no instr_valid for that instruction. Next mem_addr=0x40. Also: redirect with ready in the same PRES cycle -> instruction consumed, next fetch at the target.
- mem[2]=0xF0 consumed -> halted=1, mem_rd stays 0 for 10 cycles. Redirect to 0x10 -> halted=0, fetch at 0x10. CLB low during F1 -> all outputs return to reset values immediately.
